counter: RTL and testbench
==========================

# counter

Modulo-(MAX+1) digit counter used for the chess-clock time digits. It advances by one on each clock edge where both the enable and the count impulse are asserted, and wraps to zero after reaching the runtime-programmable limit MAX. On wrap it raises a same-cycle carry (OVERFLOW) so digits can be cascaded: seconds-units feed seconds-tens, and so on. One instance is used per displayed digit.

## Interface
- WIDTH, default 4: counter and limit width in bits.
- CLK  input  1  rising-edge clock, shared by all clock digits.
- CLR  input  1  asynchronous, active-low reset. 0 forces COUNT to 0 immediately.
- CE  input  1  clock enable (player's clock running). 0 freezes the counter.
- IMPULSE  input  1  count request, level-sampled at each rising CLK edge. In a cascade it is tied to the OVERFLOW of the lower digit or to the timebase tick.
- MAX  input  WIDTH  terminal value (inclusive). May change at any time.
- COUNT  output  WIDTH  current value, registered.
- OVERFLOW  output  1  carry out, combinational: CE & IMPULSE & (COUNT >= MAX).

## Operation
- Advance condition: adv = CE & IMPULSE.
- On a rising CLK edge with CLR=1:
  - adv=0: COUNT holds.
  - adv=1 and COUNT < MAX: COUNT ← COUNT+1.
  - adv=1 and COUNT >= MAX: COUNT ← 0.
- OVERFLOW is asserted exactly in the cycle whose closing edge performs the wrap.
- Comparisons are unsigned, full WIDTH. No arithmetic wraps past 2^WIDTH−1, because the terminal test uses >=.
- MAX lowered below the current COUNT: the next advance wraps to 0 with OVERFLOW. Without an advance, COUNT holds the out-of-range value.
- MAX=0: COUNT stays 0, and OVERFLOW = adv on every cycle (divide-by-1).
- MAX = 2^WIDTH−1: full binary range.
- IMPULSE held high for N edges (with CE=1) advances the counter N times. No edge detection is performed inside the block.
- CE=0 masks both counting and OVERFLOW.

## Timing
- Reset: CLR=0 drives COUNT=0 asynchronously. OVERFLOW is then 0 unless MAX=0 and adv=1. Release is synchronised externally; the first advance can occur on the first edge after CLR goes high.
- Reset mid-count: COUNT drops to 0 without waiting for a clock edge. The advance in progress is discarded.
- Latency: one clock from sampled adv to the COUNT update.
- OVERFLOW has zero latency (combinational from IMPULSE, CE, COUNT, MAX). A cascaded higher digit therefore increments on the same edge on which the lower digit wraps.
- The OVERFLOW path has no combinational loop, because it does not depend on its own output.

## Structure
- A single module; no sub-module is needed.
- The shared chess-clock package holds the per-digit limit constants: units limit 9, tens-of-seconds limit 5, and the default WIDTH=4. Callers drive MAX from these constants.
- RTL contents:
  - Registered COUNT with async active-low clear.
  - Next-state mux.
  - Terminal comparator (COUNT >= MAX).
  - OVERFLOW gate.
  - Parameter sanity check (WIDTH ≥ 1).

## Test plan
- Reset: CLR=0, CE=1, IMPULSE=0, MAX=5 → COUNT=0, OVERFLOW=0. Release CLR with IMPULSE=0 → COUNT stays 0.
- Continuous count: CE=1, MAX=5, IMPULSE=1 held for 8 edges → COUNT 1,2,3,4,5,0,1,2. OVERFLOW=1 only while COUNT=5.
- Async reset mid-count: at COUNT=3, CLR=0 between edges → COUNT=0 before the next edge. CLR=1 with IMPULSE=1 → COUNT=1 after one edge.
- Enable masking: COUNT=5, MAX=5, IMPULSE=1, CE=0 for 3 edges → COUNT holds at 5, OVERFLOW=0. CE=1 → OVERFLOW=1, then COUNT=0.
- MAX change: COUNT=7, MAX set to 4, one advance → OVERFLOW=1 in that cycle, then COUNT=0. With MAX=0 and IMPULSE=1 → COUNT=0 and OVERFLOW=1 every cycle.
- Cascade: two instances, lower MAX=9 with IMPULSE=1, upper MAX=5 with IMPULSE=lower.OVERFLOW, both CE=1 → after 60 edges both read 0, upper OVERFLOW pulsed once (at 59), and the upper digit steps on every 10th edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared chess-clock definitions: per-digit limits, default digit width and
// the next-state selector used by each digit counter.
package counter_pkg;

    localparam int unsigned DIGIT_WIDTH  = 4;
    localparam int unsigned UNITS_MAX    = 9;
    localparam int unsigned TENS_SEC_MAX = 5;

    typedef enum logic {
        DIGIT_UNITS    = 1'b0,
        DIGIT_TENS_SEC = 1'b1
    } digit_e;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_INC  = 2'd1,
        SEL_WRAP = 2'd2
    } next_sel_e;

    // Terminal value a caller should drive onto a digit's limit input.
    function automatic logic [DIGIT_WIDTH-1:0] digit_max(input digit_e kind);
        logic [DIGIT_WIDTH-1:0] lim;
        lim = DIGIT_WIDTH'(UNITS_MAX);
        case (kind)
            DIGIT_UNITS:    lim = DIGIT_WIDTH'(UNITS_MAX);
            DIGIT_TENS_SEC: lim = DIGIT_WIDTH'(TENS_SEC_MAX);
            default:        lim = DIGIT_WIDTH'(UNITS_MAX);
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/counter.sv
// Modulo-(MAX+1) chess-clock digit with same-cycle carry out for cascading.
// MAX is sampled live; a count above MAX wraps on its next advance.
module counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DIGIT_WIDTH
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic             ce_i,
    input  logic             impulse_i,
    input  logic [WIDTH-1:0] max_i,
    output logic [WIDTH-1:0] count_o,
    output logic             overflow_c_o
);

    if (WIDTH < 1) begin : g_bad_width
        $error("counter: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             adv_c;
    logic             term_c;
    next_sel_e        sel_c;

    assign adv_c  = ce_i & impulse_i;
    // >= rather than == so an out-of-range count recovers on the next advance
    assign term_c = (count_q >= max_i);

    always_comb begin
        sel_c = SEL_HOLD;
        if (adv_c) begin
            sel_c = term_c ? SEL_WRAP : SEL_INC;
        end
    end

    always_comb begin
        count_d = count_q;
        case (sel_c)
            SEL_INC:  count_d = count_q + WIDTH'(1);
            SEL_WRAP: count_d = '0;
            default:  count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign overflow_c_o = adv_c & term_c;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for the digit counter: each driven cycle queues the
// expected COUNT/OVERFLOW, and a negedge monitor compares them.
module tb_counter;

    logic       clk;
    logic       clr_n;
    logic       ce;
    logic       imp;
    logic [3:0] mx;
    logic [3:0] cnt;
    logic       ovf;

    logic       cas_clr_n;
    logic       cas_ce;
    logic       cas_imp;
    logic [3:0] lo_cnt;
    logic       lo_ovf;
    logic [3:0] hi_cnt;
    logic       hi_ovf;

    typedef struct {
        string      name;
        logic       chk_main;
        logic [3:0] cnt;
        logic       ovf;
        logic       chk_cas;
        logic [3:0] lo_cnt;
        logic       lo_ovf;
        logic [3:0] hi_cnt;
        logic       hi_ovf;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_push  = 0;
    int   n_pop   = 0;

    counter #(.WIDTH(4)) u_dut (
        .clk_i       (clk),
        .clr_ni      (clr_n),
        .ce_i        (ce),
        .impulse_i   (imp),
        .max_i       (mx),
        .count_o     (cnt),
        .overflow_c_o(ovf)
    );

    counter #(.WIDTH(4)) u_lo (
        .clk_i       (clk),
        .clr_ni      (cas_clr_n),
        .ce_i        (cas_ce),
        .impulse_i   (cas_imp),
        .max_i       (4'd9),
        .count_o     (lo_cnt),
        .overflow_c_o(lo_ovf)
    );

    counter #(.WIDTH(4)) u_hi (
        .clk_i       (clk),
        .clr_ni      (cas_clr_n),
        .ce_i        (cas_ce),
        .impulse_i   (lo_ovf),
        .max_i       (4'd5),
        .count_o     (hi_cnt),
        .overflow_c_o(hi_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, half a period after the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_pop++;
                if (e.chk_main) begin
                    chk({e.name, ".count"}, int'(cnt), int'(e.cnt));
                    chk({e.name, ".overflow"}, int'(ovf), int'(e.ovf));
                end
                if (e.chk_cas) begin
                    chk({e.name, ".lo_count"}, int'(lo_cnt), int'(e.lo_cnt));
                    chk({e.name, ".lo_overflow"}, int'(lo_ovf), int'(e.lo_ovf));
                    chk({e.name, ".hi_count"}, int'(hi_cnt), int'(e.hi_cnt));
                    chk({e.name, ".hi_overflow"}, int'(hi_ovf), int'(e.hi_ovf));
                end
            end
        end
    end

    // One row = one cycle: inputs applied, then the COUNT/OVERFLOW seen before the next edge.
    task automatic step(input string name, input logic c_n, input logic c_e,
                        input logic im, input logic [3:0] m,
                        input logic [3:0] ec, input logic eo);
        exp_t e;
        clr_n = c_n;
        ce    = c_e;
        imp   = im;
        mx    = m;
        e.name = name;  e.chk_main = 1'b1; e.cnt = ec; e.ovf = eo;
        e.chk_cas = 1'b0; e.lo_cnt = '0; e.lo_ovf = 1'b0; e.hi_cnt = '0; e.hi_ovf = 1'b0;
        q.push_back(e);
        n_push++;
        @(posedge clk);
        #2;
    endtask

    task automatic cas_step(input string name, input logic [3:0] elo, input logic elo_o,
                            input logic [3:0] ehi, input logic ehi_o);
        exp_t e;
        e.name = name;  e.chk_main = 1'b0; e.cnt = '0; e.ovf = 1'b0;
        e.chk_cas = 1'b1; e.lo_cnt = elo; e.lo_ovf = elo_o; e.hi_cnt = ehi; e.hi_ovf = ehi_o;
        q.push_back(e);
        n_push++;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n = 1'b0; ce = 1'b1; imp = 1'b0; mx = 4'd5;
        cas_clr_n = 1'b0; cas_ce = 1'b0; cas_imp = 1'b0;
        @(posedge clk);
        #2;

        // Reset and release with no impulse
        step("rst",      0, 1, 0, 5, 0, 0);
        step("rst",      0, 1, 0, 5, 0, 0);
        step("rel",      1, 1, 0, 5, 0, 0);
        step("rel",      1, 1, 0, 5, 0, 0);

        // Continuous count to MAX=5 and wrap
        step("cont",     1, 1, 1, 5, 0, 0);
        step("cont",     1, 1, 1, 5, 1, 0);
        step("cont",     1, 1, 1, 5, 2, 0);
        step("cont",     1, 1, 1, 5, 3, 0);
        step("cont",     1, 1, 1, 5, 4, 0);
        step("cont",     1, 1, 1, 5, 5, 1);
        step("cont",     1, 1, 1, 5, 0, 0);
        step("cont",     1, 1, 1, 5, 1, 0);
        step("cont",     1, 1, 1, 5, 2, 0);

        // Async clear mid-count, then restart
        step("mid3",     1, 1, 0, 5, 3, 0);
        step("aclr",     0, 1, 1, 5, 0, 0);
        step("aclr_rel", 1, 1, 1, 5, 0, 0);
        step("aclr_one", 1, 1, 0, 5, 1, 0);

        // Enable masks counting and carry
        step("to5",      1, 1, 1, 5, 1, 0);
        step("to5",      1, 1, 1, 5, 2, 0);
        step("to5",      1, 1, 1, 5, 3, 0);
        step("to5",      1, 1, 1, 5, 4, 0);
        step("ce_off",   1, 0, 1, 5, 5, 0);
        step("ce_off",   1, 0, 1, 5, 5, 0);
        step("ce_off",   1, 0, 1, 5, 5, 0);
        step("ce_on",    1, 1, 1, 5, 5, 1);
        step("ce_wrap",  1, 1, 0, 5, 0, 0);

        // MAX lowered below COUNT
        for (int i = 0; i < 7; i++) step("to7", 1, 1, 1, 9, 4'(i), 0);
        step("lower_hold", 1, 1, 0, 4, 7, 0);
        step("lower_adv",  1, 1, 1, 4, 7, 1);
        step("lower_wrap", 1, 1, 0, 4, 0, 0);

        // MAX=0 divide-by-1
        step("max0",     1, 1, 1, 0, 0, 1);
        step("max0",     1, 1, 1, 0, 0, 1);
        step("max0",     1, 1, 1, 0, 0, 1);
        step("max0_ce0", 1, 0, 1, 0, 0, 0);
        step("max0_idle",1, 1, 0, 0, 0, 0);

        // Full binary range
        for (int i = 0; i < 16; i++) step("full", 1, 1, 1, 15, 4'(i), (i == 15));
        step("full_wrap", 1, 1, 0, 15, 0, 0);

        // Two-digit cascade 0..59
        cas_clr_n = 1'b1;
        cas_ce    = 1'b1;
        cas_imp   = 1'b1;
        for (int k = 0; k < 60; k++)
            cas_step("cas", 4'(k % 10), (k % 10 == 9), 4'(k / 10), (k == 59));
        cas_imp = 1'b0;
        cas_step("cas_end", 0, 0, 0, 0);

        @(negedge clk);
        #1;
        chk("sb_drained", n_pop, n_push);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
